// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA decryption block and its serial modular multiplier.
package rsa_pkg;

    localparam int unsigned RSA_WIDTH_DEF     = 512;
    localparam int unsigned RSA_EXP_WIDTH_DEF = 512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SQR   = 3'd2,
        ST_MUL   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } rsa_state_e;

    // Cycles per modular product: one operand-load cycle plus one cycle per bit.
    function automatic int unsigned mm_latency(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/rsa_decryption_if.sv
// Start/busy/done request interface of the RSA decryption block.
interface rsa_decryption_if
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH     = RSA_WIDTH_DEF,
    parameter int unsigned EXP_WIDTH = RSA_EXP_WIDTH_DEF
) ();

    logic                 start;
    logic [WIDTH-1:0]     Cipher_word;
    logic [EXP_WIDTH-1:0] Exp_privateKey;
    logic [WIDTH-1:0]     Mod_n;
    logic                 busy;
    logic [WIDTH-1:0]     Decrypted_Data;
    logic                 Decrypt_done;
    logic                 Decrypt_err;

    modport master (
        output start, Cipher_word, Exp_privateKey, Mod_n,
        input  busy, Decrypted_Data, Decrypt_done, Decrypt_err
    );

    modport slave (
        input  start, Cipher_word, Exp_privateKey, Mod_n,
        output busy, Decrypted_Data, Decrypt_done, Decrypt_err
    );

endinterface

// File: rtl/rsa_modmul_serial.sv
// Bit-serial interleaved modular multiplier: P = A*B mod N, MSB of A first, WIDTH+1 cycles.
module rsa_modmul_serial
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH_DEF
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             mm_start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] N,
    output logic             mm_done,
    output logic [WIDTH-1:0] P
);

    localparam int unsigned JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, p_q, p_d;
    logic [JW-1:0]    j_q, j_d;
    logic             active_q, active_d;
    logic [WIDTH+1:0] acc0, acc1, acc2;

    always_comb begin
        // 2P + B < 3N, so two conditional subtractions bring the sum back below N.
        acc0 = {1'b0, p_q, 1'b0} + (a_q[j_q] ? {2'b00, b_q} : '0);
        acc1 = (acc0 >= {2'b00, n_q}) ? acc0 - {2'b00, n_q} : acc0;
        acc2 = (acc1 >= {2'b00, n_q}) ? acc1 - {2'b00, n_q} : acc1;

        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        p_d      = p_q;
        j_d      = j_q;
        active_d = active_q;
        mm_done  = active_q && (j_q == '0);

        if (mm_start) begin
            a_d      = A;
            b_d      = B;
            n_d      = N;
            p_d      = '0;
            j_d      = JW'(WIDTH - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            p_d = acc2[WIDTH-1:0];
            j_d = j_q - 1'b1;
            if (j_q == '0) begin
                active_d = 1'b0;
            end
        end
    end

    assign P = acc2[WIDTH-1:0];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            p_q      <= '0;
            j_q      <= '0;
            active_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            p_q      <= p_d;
            j_q      <= j_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/rsa_decryption.sv
// RSA decryption M = C^d mod n, left-to-right square-and-multiply over a shared serial multiplier.
// Define RSA_DEC_FAST_EN to skip leading zero exponent bits and unneeded multiplies (data-dependent timing).
module rsa_decryption
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH     = RSA_WIDTH_DEF,
    parameter int unsigned EXP_WIDTH = RSA_EXP_WIDTH_DEF
) (
    input  logic             aclk,
    input  logic             aresetn,
    rsa_decryption_if.slave  bus
);

    localparam int unsigned IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam int unsigned CW = $clog2(WIDTH + 2);

    rsa_state_e           state_q, state_d;
    logic [WIDTH-1:0]     c_q, c_d, n_q, n_d, r_q, r_d, data_q, data_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [IW-1:0]        i_q, i_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic                 mm_run_q, mm_run_d, busy_q, busy_d;
    logic                 done_q, done_d, err_q, err_d;
    logic                 mm_start, mm_done;
    logic [WIDTH-1:0]     mm_b, mm_p;

`ifdef RSA_DEC_FAST_EN
    logic [IW-1:0] msb;
    always_comb begin
        msb = '0;
        for (int unsigned k = 0; k < EXP_WIDTH; k++) begin
            if (exp_q[k]) msb = IW'(k);
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        n_d      = n_q;
        r_d      = r_q;
        exp_d    = exp_q;
        i_d      = i_q;
        mm_run_d = mm_run_q;
        busy_d   = busy_q;
        data_d   = data_q;
        done_d   = 1'b0;
        err_d    = err_q;
        mm_start = 1'b0;
        mm_b     = r_q;
        cyc_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    c_d     = bus.Cipher_word;
                    exp_d   = bus.Exp_privateKey;
                    n_d     = bus.Mod_n;
                    r_d     = WIDTH'(1);
                    i_d     = IW'(EXP_WIDTH - 1);
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!n_q[0] || (n_q < WIDTH'(3)) || (c_q >= n_q)) begin
                    err_d   = 1'b1;
                    r_d     = '0;
                    state_d = ST_DONE;
                end else begin
`ifdef RSA_DEC_FAST_EN
                    if (exp_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d     = msb;
                        state_d = ST_SQR;
                    end
`else
                    state_d = ST_SQR;
`endif
                end
            end
            ST_SQR, ST_MUL: begin
                // First cycle in the state loads the multiplier; it reports done WIDTH cycles later.
                mm_start = !mm_run_q;
                mm_run_d = 1'b1;
                mm_b     = (state_q == ST_MUL) ? c_q : r_q;
                cyc_d    = cyc_q + 1'b1;
                if (mm_done) begin
                    mm_run_d = 1'b0;
                    cyc_d    = '0;
                    if (state_q == ST_SQR) begin
                        r_d     = mm_p;
                        state_d = ST_MUL;
                    end
                    if (state_q == ST_MUL && exp_q[i_q]) begin
                        r_d = mm_p;
                    end
`ifdef RSA_DEC_FAST_EN
                    if (state_q == ST_MUL || !exp_q[i_q]) begin
`else
                    if (state_q == ST_MUL) begin
`endif
                        if (i_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            i_d     = i_q - 1'b1;
                            state_d = ST_SQR;
                        end
                    end
                end
            end
            ST_DONE: begin
                data_d  = r_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    rsa_modmul_serial #(.WIDTH(WIDTH)) u_modmul (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .mm_start (mm_start),
        .A        (r_q),
        .B        (mm_b),
        .N        (n_q),
        .mm_done  (mm_done),
        .P        (mm_p)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            c_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            exp_q    <= '0;
            i_q      <= '0;
            cyc_q    <= '0;
            mm_run_q <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            n_q      <= n_d;
            r_q      <= r_d;
            exp_q    <= exp_d;
            i_q      <= i_d;
            cyc_q    <= cyc_d;
            mm_run_q <= mm_run_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && mm_done) begin
            assert (32'(cyc_q) == mm_latency(WIDTH) - 1)
                else $error("modmul product took an unexpected number of cycles");
        end
    end

    assign bus.busy           = busy_q;
    assign bus.Decrypted_Data = data_q;
    assign bus.Decrypt_done   = done_q;
    assign bus.Decrypt_err    = err_q;

endmodule

// File: tb/tb_rsa_decryption.sv
// Self-checking bench for rsa_decryption at WIDTH=EXP_WIDTH=16 against a plain-arithmetic modexp model.
module tb_rsa_decryption;
    import rsa_pkg::*;

    localparam int unsigned W   = 16;
    localparam int unsigned E   = 16;
    localparam int unsigned LAT = 2 + 2 * E * mm_latency(W);

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    rsa_decryption_if #(.WIDTH(W), .EXP_WIDTH(E)) bus ();

    rsa_decryption #(.WIDTH(W), .EXP_WIDTH(E)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit ref_err(input longint unsigned c, input longint unsigned n);
        return (n % 2 == 0) || (n < 3) || (c >= n);
    endfunction

    function automatic longint unsigned ref_modexp(input longint unsigned c,
                                                   input longint unsigned d,
                                                   input longint unsigned n);
        longint unsigned r = 1;
        if (ref_err(c, n)) return 0;
        for (int k = E - 1; k >= 0; k--) begin
            r = (r * r) % n;
            if (d[k]) r = (r * c) % n;
        end
        return r;
    endfunction

    function automatic int ref_latency(input longint unsigned c,
                                       input longint unsigned d,
                                       input longint unsigned n);
        if (ref_err(c, n)) return 2;
`ifdef RSA_DEC_FAST_EN
        begin
            int nb = 0;
            if (d == 0) return 2;
            for (int k = 0; k < E; k++) if (d[k]) nb = k + 1;
            return 2 + (nb + $countones(d[E-1:0])) * int'(mm_latency(W));
        end
`else
        return LAT;
`endif
    endfunction

    // Starts in the current cycle; returns #1 after the edge where done rose (or after the bound).
    task automatic run_op(input logic [W-1:0] c, input logic [E-1:0] d, input logic [W-1:0] n,
                          input int stray_at, output int cycles);
        bus.Cipher_word    = c;
        bus.Exp_privateKey = d;
        bus.Mod_n          = n;
        bus.start          = 1'b1;
        @(posedge aclk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_accept", bus.busy, 1);
        cycles = 0;
        while (cycles < 4 * LAT) begin
            @(posedge aclk);
            #1;
            cycles++;
            bus.start = 1'b0;
            if (bus.Decrypt_done) break;
            if (cycles == stray_at) begin
                bus.Cipher_word    = 16'd1234;
                bus.Exp_privateKey = 16'd17;
                bus.Mod_n          = 16'd2047;
                bus.start          = 1'b1;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] c, input logic [E-1:0] d,
                            input logic [W-1:0] n);
        int cyc;
        run_op(c, d, n, -1, cyc);
        chk({tag, "_latency"}, cyc, ref_latency(c, d, n));
        chk({tag, "_data"}, bus.Decrypted_Data, ref_modexp(c, d, n));
        chk({tag, "_err"}, bus.Decrypt_err, ref_err(c, n));
        chk({tag, "_busy_low"}, bus.busy, 0);
    endtask

    task automatic count_dones(input int window, output int dones);
        dones = 0;
        repeat (window) begin
            @(posedge aclk);
            #1;
            if (bus.Decrypt_done) dones++;
        end
    endtask

    initial begin
        int cyc;
        int dones;
        logic [W-1:0] rn, rc;
        logic [E-1:0] rd;

        bus.start          = 1'b0;
        bus.Cipher_word    = '0;
        bus.Exp_privateKey = '0;
        bus.Mod_n          = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_data", bus.Decrypted_Data, 0);
        chk("reset_done", bus.Decrypt_done, 0);
        chk("reset_err", bus.Decrypt_err, 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        check_op("textbook", 16'd2790, 16'd2753, 16'd3233);
        chk("textbook_exact", bus.Decrypted_Data, 65);
        check_op("c_zero", 16'd0, 16'd2753, 16'd3233);
        check_op("c_one", 16'd1, 16'd2753, 16'd3233);
        check_op("d_zero", 16'd1234, 16'd0, 16'd3233);
        chk("d_zero_exact", bus.Decrypted_Data, 1);
        check_op("n_even", 16'd2790, 16'd2753, 16'd3232);
        check_op("c_eq_n", 16'd3233, 16'd2753, 16'd3233);
        check_op("n_one", 16'd0, 16'd5, 16'd1);

        // Stray start mid-operation must neither disturb the result nor queue a second run.
        @(posedge aclk);
        #1;
        run_op(16'd2790, 16'd2753, 16'd3233, 100, cyc);
        chk("stray_latency", cyc, LAT);
        chk("stray_data", bus.Decrypted_Data, 65);
        count_dones(LAT + 20, dones);
        chk("stray_single_done", dones, 0);

        // Reset in the middle of an operation aborts it silently.
        bus.Cipher_word    = 16'd2790;
        bus.Exp_privateKey = 16'd2753;
        bus.Mod_n          = 16'd3233;
        bus.start          = 1'b1;
        @(posedge aclk);
        #1;
        bus.start = 1'b0;
        repeat (200) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_data", bus.Decrypted_Data, 0);
        chk("midreset_done", bus.Decrypt_done, 0);
        chk("midreset_err", bus.Decrypt_err, 0);
        aresetn = 1'b1;
        count_dones(LAT + 20, dones);
        chk("midreset_no_done", dones, 0);
        check_op("after_reset", 16'd2790, 16'd2753, 16'd3233);

        // Back-to-back: each new start issued in the same cycle its predecessor's done is high.
        check_op("b2b_first", 16'd42, 16'd2753, 16'd3233);
        check_op("b2b_second", 16'd2790, 16'd2753, 16'd3233);

        for (int k = 0; k < 16; k++) begin
            rn = 16'($urandom_range(3, 65535)) | 16'd1;
            rc = 16'($urandom_range(0, int'(rn) - 1));
            rd = 16'($urandom);
            if (k % 7 == 3) rn = rn & 16'hfffe;
            if (k % 5 == 2) rc = rn;
            check_op("random", rc, rd, rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
